// File: rtl/jtpang_obj_linebuf_if.sv
// rtl/jtpang_obj_linebuf_if.sv - scan, draw and status signals of the object line buffer
interface jtpang_obj_linebuf_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          pxl_cen;
    logic          LHBL;
    logic [AW-1:0] hdump;
    logic          draw_we;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_data;
    logic          line_start;
    logic          init_busy;
    logic [DW-1:0] obj_pxl;

    modport master (
        output pxl_cen, LHBL, hdump, draw_we, draw_addr, draw_data,
        input  line_start, init_busy, obj_pxl
    );

    modport slave (
        input  pxl_cen, LHBL, hdump, draw_we, draw_addr, draw_data,
        output line_start, init_busy, obj_pxl
    );
endinterface

// File: rtl/jtpang_obj_linebuf.sv
// rtl/jtpang_obj_linebuf.sv - ping-pong object line buffer with erase-after-read scan-out
module jtpang_obj_linebuf #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    jtpang_obj_linebuf_if.slave   bus
);
    localparam int            DEPTH = 1 << AW;
    localparam logic [DW-1:0] BLANK = {DW{1'b1}};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] init_cnt, init_cnt_nx;
    logic          running;

    logic          bank_sel;
    logic          lhbl_r;
    logic          lhbl_fall;
    logic          line_start_r;

    logic          scan_rd;
    logic          rd_pend;
    logic [AW-1:0] hdump_reg;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] hold;
    logic [DW-1:0] obj_pxl_r;

    logic          draw_ok;
    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [DW-1:0] bank0 [DEPTH];
    logic [DW-1:0] bank1 [DEPTH];

    assign running        = (state == ST_RUN);
    assign bus.init_busy  = ~running;
    assign bus.line_start = line_start_r;
    assign bus.obj_pxl    = obj_pxl_r;

    assign lhbl_fall = lhbl_r & ~bus.LHBL;
    assign scan_rd   = running & bus.pxl_cen & bus.LHBL;
    assign draw_ok   = running & bus.draw_we & (bus.draw_data[3:0] != 4'hF);

    // Clear sequencer: state and sweep address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    // Clear sequencer: one address per clk, leave after the last address
    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        case (state)
            ST_INIT: begin
                init_cnt_nx = init_cnt + AW'(1);
                if (init_cnt == '1) state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    // Bank swap on the falling edge of LHBL; line_start follows one clk later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lhbl_r       <= 1'b0;
            bank_sel     <= 1'b0;
            line_start_r <= 1'b0;
        end else begin
            lhbl_r       <= bus.LHBL;
            line_start_r <= lhbl_fall & running;
            if (lhbl_fall) bank_sel <= ~bank_sel;
        end
    end

    // Scan read port of the active scan bank
    always_ff @(posedge clk) begin
        if (scan_rd) rd_q <= bank_sel ? bank1[bus.hdump] : bank0[bus.hdump];
    end

    // Scan pipeline: capture read data into hold, present it at the next pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            hdump_reg <= '0;
            hold      <= BLANK;
            obj_pxl_r <= BLANK;
        end else if (!running) begin
            rd_pend   <= 1'b0;
            hold      <= BLANK;
            obj_pxl_r <= BLANK;
        end else begin
            rd_pend <= scan_rd;
            if (scan_rd) hdump_reg <= bus.hdump;
            if (rd_pend) hold <= rd_q;
            if (bus.pxl_cen) begin
                if (bus.LHBL) begin
                    obj_pxl_r <= hold;
                end else begin
                    obj_pxl_r <= BLANK;
                    hold      <= BLANK;
                end
            end
        end
    end

    // Write port steering: clear sweep, else draw into ~bank_sel and erase in bank_sel
    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wa0 = bus.draw_addr;
        wa1 = bus.draw_addr;
        wd0 = bus.draw_data;
        wd1 = bus.draw_data;
        if (!running) begin
            we0 = 1'b1;
            we1 = 1'b1;
            wa0 = init_cnt;
            wa1 = init_cnt;
            wd0 = BLANK;
            wd1 = BLANK;
        end else begin
            if (draw_ok) begin
                if (bank_sel) we0 = 1'b1;
                else          we1 = 1'b1;
            end
            if (rd_pend) begin
                if (bank_sel) begin
                    we1 = 1'b1;
                    wa1 = hdump_reg;
                    wd1 = BLANK;
                end else begin
                    we0 = 1'b1;
                    wa0 = hdump_reg;
                    wd0 = BLANK;
                end
            end
        end
    end

    // Line RAM bank 0 write port
    always_ff @(posedge clk) begin
        if (we0) bank0[wa0] <= wd0;
    end

    // Line RAM bank 1 write port
    always_ff @(posedge clk) begin
        if (we1) bank1[wa1] <= wd1;
    end
endmodule

// File: tb/tb_jtpang_obj_linebuf.sv
// tb/tb_jtpang_obj_linebuf.sv - self-checking bench for the object line buffer
module tb_jtpang_obj_linebuf;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jtpang_obj_linebuf_if #(.AW(AW), .DW(DW)) bus ();
    jtpang_obj_linebuf #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mb [2][N];
    logic       msel;
    logic [7:0] mprev;
    logic       in_init;
    int         exp_ls;

    int   ls_count = 0;
    logic ls_prev  = 1'b0;

    typedef struct {
        int         a;
        logic [7:0] da;
        int         b;
        logic [7:0] db;
        int         probe;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [7];

    always @(negedge clk) begin
        if (bus.line_start && !ls_prev) ls_count++;
        ls_prev = bus.line_start;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_draw(int addr, logic [7:0] d);
        if (!in_init && d[3:0] != 4'hF) mb[~msel][addr % N] = d;
    endfunction

    task automatic draw(int addr, logic [7:0] d);
        bus.draw_we   = 1'b1;
        bus.draw_addr = addr[AW-1:0];
        bus.draw_data = d;
        model_draw(addr, d);
        cyc();
        bus.draw_we = 1'b0;
    endtask

    task automatic scan_px(int x, logic rnd, string name);
        logic [7:0] exp;
        int         ra;
        logic [7:0] rd;
        bus.hdump   = x[AW-1:0];
        bus.pxl_cen = 1'b1;
        exp         = mprev;
        mprev       = mb[msel][x % N];
        mb[msel][x % N] = 8'hFF;
        cyc();
        bus.pxl_cen = 1'b0;
        check(name, bus.obj_pxl, exp);
        if (rnd && ($urandom_range(0, 1) == 1)) begin
            ra = (500 + $urandom_range(0, 39)) % N;
            rd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd[3:0] = 4'hF;
            bus.draw_we   = 1'b1;
            bus.draw_addr = ra[AW-1:0];
            bus.draw_data = rd;
            model_draw(ra, rd);
        end
        cyc();
        bus.draw_we = 1'b0;
    endtask

    task automatic blank_px(string name);
        bus.pxl_cen = 1'b1;
        mprev       = 8'hFF;
        cyc();
        bus.pxl_cen = 1'b0;
        check(name, bus.obj_pxl, 8'hFF);
        cyc();
    endtask

    task automatic lhbl_rise();
        bus.LHBL = 1'b1;
        cyc();
    endtask

    task automatic lhbl_fall(logic dw, int addr, logic [7:0] d);
        bus.LHBL = 1'b0;
        if (dw) begin
            bus.draw_we   = 1'b1;
            bus.draw_addr = addr[AW-1:0];
            bus.draw_data = d;
            model_draw(addr, d);
        end
        msel = ~msel;
        cyc();
        bus.draw_we = 1'b0;
        if (in_init) begin
            check("line_start_init", bus.line_start, 1'b0);
        end else begin
            check("line_start_hi", bus.line_start, 1'b1);
            exp_ls++;
        end
        cyc();
        check("line_start_width", bus.line_start, 1'b0);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.LHBL      = 1'b0;
        bus.pxl_cen   = 1'b0;
        bus.draw_we   = 1'b0;
        bus.hdump     = '0;
        bus.draw_addr = '0;
        bus.draw_data = '0;
        cyc();
        check("rst_obj_pxl", bus.obj_pxl, 8'hFF);
        check("rst_init_busy", bus.init_busy, 1'b1);
        check("rst_line_start", bus.line_start, 1'b0);
        cyc();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) mb[b][i] = 8'hFF;
        msel    = 1'b0;
        mprev   = 8'hFF;
        in_init = 1'b1;
        rst     = 1'b0;
    endtask

    task automatic wait_init(int exp_len, string name);
        int n;
        n = 0;
        while (bus.init_busy && n < 600) begin
            n++;
            cyc();
        end
        check(name, n, exp_len);
        in_init = 1'b0;
    endtask

    initial begin
        int start;
        int len;
        int ra;
        logic [7:0] rd;

        tbl[0] = '{10,  8'h23, 11,  8'h4F, 10,  8'h23};
        tbl[1] = '{10,  8'h23, 11,  8'h4F, 11,  8'hFF};
        tbl[2] = '{100, 8'h11, 100, 8'h57, 100, 8'h57};
        tbl[3] = '{511, 8'hAA, 512, 8'hBB, 0,   8'hBB};
        tbl[4] = '{511, 8'hAA, 512, 8'hBB, 511, 8'hAA};
        tbl[5] = '{200, 8'h3C, 200, 8'h7F, 200, 8'h3C};
        tbl[6] = '{300, 8'hF0, 301, 8'h0E, 301, 8'h0E};
        exp_ls = 0;

        // Reset, then a dropped draw and a suppressed swap pulse during the clear
        do_reset();
        draw(5, 8'h12);
        lhbl_rise();
        lhbl_fall(1'b0, 0, 8'h00);
        wait_init(508, "init_len_with_activity");

        // Both banks read blank everywhere after the clear
        for (int k = 0; k < 2; k++) begin
            lhbl_rise();
            for (int x = 0; x < N; x++) scan_px(x, 1'b0, "init_clear_scan");
            lhbl_fall(1'b0, 0, 8'h00);
            blank_px("blank_after_clear");
        end

        // Table vectors: two draws, swap, scan probe and probe+1
        for (int i = 0; i < 7; i++) begin
            draw(tbl[i].a, tbl[i].da);
            draw(tbl[i].b, tbl[i].db);
            lhbl_rise();
            lhbl_fall(1'b0, 0, 8'h00);
            lhbl_rise();
            scan_px(tbl[i].probe, 1'b0, "tbl_scan");
            scan_px(tbl[i].probe + 1, 1'b0, "tbl_scan");
            check($sformatf("tbl_exp_%0d", i), bus.obj_pxl, tbl[i].exp);
            scan_px(tbl[i].a, 1'b0, "tbl_cleanup");
            scan_px(tbl[i].b, 1'b0, "tbl_cleanup");
            lhbl_fall(1'b0, 0, 8'h00);
            blank_px("tbl_blank");
        end

        // Scanned locations are erased: same bank two swaps later is blank
        draw(10, 8'h23);
        draw(11, 8'h4F);
        lhbl_rise();
        lhbl_fall(1'b0, 0, 8'h00);
        lhbl_rise();
        scan_px(10, 1'b0, "erase_first");
        scan_px(11, 1'b0, "erase_first");
        check("erase_first_val", bus.obj_pxl, 8'h23);
        lhbl_fall(1'b0, 0, 8'h00);
        lhbl_rise();
        lhbl_fall(1'b0, 0, 8'h00);
        lhbl_rise();
        scan_px(10, 1'b0, "erase_rescan");
        scan_px(11, 1'b0, "erase_rescan");
        check("erase_rescan_10", bus.obj_pxl, 8'hFF);
        scan_px(12, 1'b0, "erase_rescan");
        check("erase_rescan_11", bus.obj_pxl, 8'hFF);
        lhbl_fall(1'b0, 0, 8'h00);
        blank_px("erase_blank");

        // Draw in the swap clk lands in the bank scanned on the very next line
        lhbl_rise();
        lhbl_fall(1'b1, 50, 8'h6A);
        lhbl_rise();
        scan_px(50, 1'b0, "swap_draw");
        scan_px(51, 1'b0, "swap_draw");
        check("swap_draw_val", bus.obj_pxl, 8'h6A);
        lhbl_fall(1'b0, 0, 8'h00);
        blank_px("swap_draw_blank");

        // Randomised lines around the address wrap, checked against the model
        for (int line = 0; line < 40; line++) begin
            for (int d = 0; d < int'($urandom_range(0, 6)); d++) begin
                ra = (500 + $urandom_range(0, 39)) % N;
                rd = 8'($urandom);
                if ($urandom_range(0, 3) == 0) rd[3:0] = 4'hF;
                draw(ra, rd);
            end
            lhbl_rise();
            start = (500 + $urandom_range(0, 20)) % N;
            len   = $urandom_range(4, 16);
            for (int k = 0; k < len; k++) scan_px((start + k) % N, 1'b1, "rnd_scan");
            ra = (500 + $urandom_range(0, 39)) % N;
            lhbl_fall(1'($urandom_range(0, 1)), ra, 8'($urandom));
            blank_px("rnd_blank");
        end

        // Reset mid-line with a pending hold value
        draw(20, 8'h41);
        draw(21, 8'h52);
        lhbl_rise();
        lhbl_fall(1'b0, 0, 8'h00);
        lhbl_rise();
        scan_px(20, 1'b0, "pre_rst");
        scan_px(21, 1'b0, "pre_rst");
        check("pre_rst_val", bus.obj_pxl, 8'h41);
        rst = 1'b1;
        #1;
        check("mid_rst_obj_pxl", bus.obj_pxl, 8'hFF);
        check("mid_rst_init_busy", bus.init_busy, 1'b1);
        do_reset();

        // Reset in the middle of the clear restarts the full sweep
        repeat (200) cyc();
        do_reset();
        wait_init(512, "init_len_restart");

        // bank_sel back at 0: draw goes to bank 1, scanned after one swap
        draw(7, 8'h35);
        lhbl_rise();
        lhbl_fall(1'b0, 0, 8'h00);
        lhbl_rise();
        scan_px(7, 1'b0, "post_rst_scan");
        scan_px(8, 1'b0, "post_rst_scan");
        check("post_rst_val", bus.obj_pxl, 8'h35);
        scan_px(20, 1'b0, "post_rst_scan");
        scan_px(21, 1'b0, "post_rst_scan");
        check("post_rst_cleared", bus.obj_pxl, 8'hFF);
        lhbl_fall(1'b0, 0, 8'h00);

        // LHBL low: blank output at every pixel enable
        for (int k = 0; k < 4; k++) blank_px("lhbl_low_blank");

        check("line_start_count", ls_count, exp_ls);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
